multi_buffer_drain: RTL and testbench

- Parametrised successor to the four-buffer read/display stage.
- Holds NCH independent FIFO channels of DEPTH entries, each DW bits wide.
- On each drain tick from the frequency divider, pops one entry from a channel chosen by latency or reliability policy. The policy is auto-selected from occupancy scores or forced externally.
- Adds per-channel write handshake, output valid/ready handshake, a pending-tick latch and starvation aging that the fixed 4x6 predecessor lacks.

---
 rtl/multi_buffer_drain_if.sv | 33 +++
 rtl/multi_buffer_drain.sv | 154 +++++++++++++++
 tb/tb_multi_buffer_drain.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_buffer_drain_if.sv
// Handshake bundle for multi_buffer_drain: write side, drain tick, mode override,
// output channel and occupancy. The design attaches as slave, its driver as master.
interface multi_buffer_drain_if #(
  parameter int NCH   = 4,
  parameter int DEPTH = 6,
  parameter int DW    = 2
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(NCH);

  logic                tick;
  logic [NCH-1:0]      in_valid;
  logic [NCH*DW-1:0]   in_data;
  logic [NCH-1:0]      in_ready;
  logic                mode_force_en;
  logic                mode_force;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic [IW-1:0]       out_ch;
  logic                out_ready;
  logic                mode;
  logic [NCH*CW-1:0]   occ;

  modport master (
    output tick, in_valid, in_data, mode_force_en, mode_force, out_ready,
    input  in_ready, out_valid, out_data, out_ch, mode, occ
  );

  modport slave (
    input  tick, in_valid, in_data, mode_force_en, mode_force, out_ready,
    output in_ready, out_valid, out_data, out_ch, mode, occ
  );
endinterface

// File: rtl/multi_buffer_drain.sv
// NCH independent FIFO channels drained one entry per tick into a valid/ready
// output slot, choosing the source by latency/reliability policy with starvation aging.
module multi_buffer_drain #(
  parameter int NCH       = 4,
  parameter int DEPTH     = 6,
  parameter int DW        = 2,
  parameter int AGE_LIMIT = 7
) (
  input logic                clk,
  input logic                rst,
  multi_buffer_drain_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(NCH);
  localparam int PW = $clog2(DEPTH);
  localparam int AW = $clog2(AGE_LIMIT + 1);
  localparam int SW = CW + 2 * IW + 2;

  logic [DW-1:0] mem_q  [NCH][DEPTH];
  logic [PW-1:0] head_q [NCH];
  logic [PW-1:0] head_d [NCH];
  logic [PW-1:0] tail_q [NCH];
  logic [PW-1:0] tail_d [NCH];
  logic [CW-1:0] occ_q  [NCH];
  logic [CW-1:0] occ_d  [NCH];
  logic [AW-1:0] age_q  [NCH];
  logic [AW-1:0] age_d  [NCH];

  logic          pending_q, pending_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [IW-1:0] out_ch_q, out_ch_d;
  logic          mode_q, mode_d;

  logic [NCH-1:0] push, pop, nonEmpty;
  logic [SW-1:0]  rs, ls;
  logic           modeUsed;
  logic           aged;
  logic [IW-1:0]  sel;
  logic [CW-1:0]  best;
  logic           drain;

  function automatic logic [PW-1:0] wrapInc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Full is judged on pre-cycle occupancy, so a full channel refuses a write even when popped.
  always_comb begin
    rs = '0;
    ls = '0;
    for (int i = 0; i < NCH; i++) begin
      nonEmpty[i] = (occ_q[i] != '0);
      push[i]     = bus.in_valid[i] && (occ_q[i] < CW'(DEPTH));
      rs          = rs + SW'(occ_q[i]) * SW'(i + 1);
      ls          = ls + SW'(occ_q[i]) * SW'(NCH - i);
    end
    modeUsed = bus.mode_force_en ? bus.mode_force : (rs >= ls);
  end

  // Starved channels win first; otherwise largest occupancy, tie direction set by mode.
  always_comb begin
    sel  = '0;
    aged = 1'b0;
    best = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (nonEmpty[i] && age_q[i] == AW'(AGE_LIMIT)) begin
        sel  = IW'(i);
        aged = 1'b1;
      end
    end
    if (!aged) begin
      for (int i = 0; i < NCH; i++) begin
        if (modeUsed ? (nonEmpty[i] && occ_q[i] >= best) : (occ_q[i] > best)) begin
          best = occ_q[i];
          sel  = IW'(i);
        end
      end
    end
  end

  assign drain = (pending_q || bus.tick) && (!out_valid_q || bus.out_ready) && (|nonEmpty);

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      pop[i]    = drain && (sel == IW'(i));
      head_d[i] = pop[i]  ? wrapInc(head_q[i]) : head_q[i];
      tail_d[i] = push[i] ? wrapInc(tail_q[i]) : tail_q[i];
      occ_d[i]  = occ_q[i] + CW'(push[i]) - CW'(pop[i]);
      age_d[i]  = age_q[i];
      if (drain) begin
        if (pop[i])
          age_d[i] = '0;
        else if (nonEmpty[i])
          age_d[i] = (age_q[i] == AW'(AGE_LIMIT)) ? age_q[i] : age_q[i] + AW'(1);
        else
          age_d[i] = '0;
      end
    end
  end

  always_comb begin
    pending_d   = drain ? 1'b0 : (pending_q || bus.tick);
    out_valid_d = drain ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
    out_data_d  = drain ? mem_q[sel][head_q[sel]] : out_data_q;
    out_ch_d    = drain ? sel : out_ch_q;
    mode_d      = drain ? modeUsed : mode_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      mode_q      <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        occ_q[i]  <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      mode_q      <= mode_d;
      for (int i = 0; i < NCH; i++) begin
        head_q[i] <= head_d[i];
        tail_q[i] <= tail_d[i];
        occ_q[i]  <= occ_d[i];
        age_q[i]  <= age_d[i];
      end
    end
  end

  // Storage needs no reset: cleared pointers already make old contents unreachable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (!rst && push[i])
        mem_q[i][tail_q[i]] <= bus.in_data[i*DW +: DW];
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : gOut
    assign bus.occ[g*CW +: CW] = occ_q[g];
    assign bus.in_ready[g]     = (occ_q[g] < CW'(DEPTH));
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.mode      = mode_q;
endmodule

// File: tb/tb_multi_buffer_drain.sv
// Directed bench for multi_buffer_drain: stimulus pushes expected drained words into a
// scoreboard queue, a negedge monitor pops and compares each accepted output word.
module tb_multi_buffer_drain;
  localparam int NCH       = 4;
  localparam int DEPTH     = 6;
  localparam int DW        = 2;
  localparam int AGE_LIMIT = 2;
  localparam int CW        = 3;
  localparam int IW        = 2;

  typedef struct packed {
    logic [IW-1:0] ch;
    logic [DW-1:0] data;
    logic          mode;
    logic          chkMode;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t expQ[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  multi_buffer_drain_if #(.NCH(NCH), .DEPTH(DEPTH), .DW(DW)) bus ();

  multi_buffer_drain #(
    .NCH(NCH), .DEPTH(DEPTH), .DW(DW), .AGE_LIMIT(AGE_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst               = 1'b1;
    bus.tick          = 1'b0;
    bus.in_valid      = '0;
    bus.in_data       = '0;
    bus.out_ready     = 1'b1;
    bus.mode_force_en = 1'b0;
    bus.mode_force    = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
    step();
    bus.in_valid = '0;
  endtask

  task automatic applyTick();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic expectWord(input int ch, input int data, input logic mode, input logic chkMode);
    exp_t e;
    e.ch      = IW'(ch);
    e.data    = DW'(data);
    e.mode    = mode;
    e.chkMode = chkMode;
    expQ.push_back(e);
  endtask

  function automatic logic [CW-1:0] occOf(input int ch);
    return bus.occ[ch*CW +: CW];
  endfunction

  // Each accepted word is compared once against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected word: got ch=%0d data=%0d, expected no output", bus.out_ch, bus.out_data);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if (bus.out_ch !== e.ch || bus.out_data !== e.data || (e.chkMode && bus.mode !== e.mode)) begin
          miscompares++;
          $display("[TB] FAIL scoreboard word: got ch=%0d data=%0d mode=%0d, expected ch=%0d data=%0d mode=%0d",
                   bus.out_ch, bus.out_data, bus.mode, e.ch, e.data, e.mode);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NCH*DW-1:0] d;

    // Reset state, then a tick with nothing stored stays pending until data arrives.
    doReset();
    checkOutput("reset out_valid", bus.out_valid, 0);
    checkOutput("reset occ", bus.occ, 0);
    checkOutput("reset mode", bus.mode, 0);
    checkOutput("reset out_ch", bus.out_ch, 0);
    checkOutput("reset out_data", bus.out_data, 0);
    checkOutput("reset in_ready", bus.in_ready, 4'hF);
    applyTick();
    step(); step(); step();
    checkOutput("idle out_valid", bus.out_valid, 0);
    checkOutput("idle occ", bus.occ, 0);
    expectWord(2, 3, 1'b0, 1'b0);
    applyStimulus(4'b0100, 8'h30);
    checkOutput("pending write occ2", occOf(2), 1);
    checkOutput("pending write out_valid", bus.out_valid, 0);
    step();
    checkOutput("pending drain out_valid", bus.out_valid, 1);
    checkOutput("pending drain occ2", occOf(2), 0);
    checkOutput("pending drain out_ch", bus.out_ch, 2);
    step(); step(); step();

    // Latency tie-break: occ=(2,2,1,0) picks ch0.
    doReset();
    bus.mode_force_en = 1'b1;
    bus.mode_force    = 1'b0;
    applyStimulus(4'b0111, {2'd0, 2'd2, 2'd3, 2'd1});
    applyStimulus(4'b0011, {2'd0, 2'd0, 2'd0, 2'd2});
    expectWord(0, 1, 1'b0, 1'b1);
    applyTick();
    checkOutput("latency out_ch", bus.out_ch, 0);
    checkOutput("latency occ0", occOf(0), 1);
    checkOutput("latency occ1", occOf(1), 2);
    step(); step(); step();

    // Reliability tie-break in auto mode: occ=(0,1,2,2), RS=16 >= LS=9 picks ch3.
    doReset();
    applyStimulus(4'b1110, {2'd3, 2'd2, 2'd1, 2'd0});
    applyStimulus(4'b1100, {2'd1, 2'd0, 2'd0, 2'd0});
    expectWord(3, 3, 1'b1, 1'b1);
    applyTick();
    checkOutput("reliability mode", bus.mode, 1);
    checkOutput("reliability out_ch", bus.out_ch, 3);
    checkOutput("reliability occ3", occOf(3), 1);
    step(); step(); step();

    // Backpressure: merged ticks give exactly one extra drain when the slot frees.
    doReset();
    bus.mode_force_en = 1'b1;
    bus.out_ready     = 1'b0;
    applyStimulus(4'b0001, 8'd1);
    applyStimulus(4'b0001, 8'd2);
    applyStimulus(4'b0001, 8'd3);
    expectWord(0, 1, 1'b0, 1'b0);
    expectWord(0, 2, 1'b0, 1'b0);
    applyTick();
    applyTick(); applyTick(); applyTick();
    checkOutput("hold out_data", bus.out_data, 1);
    checkOutput("hold occ0", occOf(0), 2);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    step(); step(); step();
    checkOutput("merged drain out_data", bus.out_data, 2);
    checkOutput("merged drain occ0", occOf(0), 1);
    bus.out_ready = 1'b1;
    step(); step(); step();
    checkOutput("merged no extra drain occ0", occOf(0), 1);
    checkOutput("merged accepted out_valid", bus.out_valid, 0);
    doReset();
    checkOutput("mid reset occ0", occOf(0), 0);
    checkOutput("mid reset out_valid", bus.out_valid, 0);

    // Aging: ch3 refilled to full, ch0 starves and is forced on the third drain.
    bus.mode_force_en = 1'b1;
    bus.mode_force    = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      d = '0;
      d[3*DW +: DW] = DW'(k % 4);
      if (k == 0) d[0 +: DW] = 2'd2;
      applyStimulus((k == 0) ? 4'b1001 : 4'b1000, d);
    end
    checkOutput("aging ch3 full in_ready", bus.in_ready[3], 0);
    checkOutput("aging ch3 occ", occOf(3), 6);
    expectWord(3, 0, 1'b0, 1'b1);
    expectWord(3, 1, 1'b0, 1'b1);
    expectWord(0, 2, 1'b0, 1'b1);
    bus.in_valid = 4'b1000;
    bus.in_data  = {2'd2, 6'd0};
    for (int k = 0; k < 3; k++) begin
      applyTick();
      step(); step();
    end
    bus.in_valid = '0;
    checkOutput("aging ch0 drained", occOf(0), 0);
    checkOutput("aging ch3 refilled", occOf(3), 6);
    step(); step();

    // Full channel drops the extra write; FIFO order holds across pointer wrap.
    doReset();
    bus.mode_force_en = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      d = '0;
      d[1*DW +: DW] = DW'(k % 4);
      applyStimulus(4'b0010, d);
    end
    checkOutput("full in_ready1", bus.in_ready[1], 0);
    d = '0;
    d[1*DW +: DW] = 2'd3;
    applyStimulus(4'b0010, d);
    checkOutput("full occ1 after 7th write", occOf(1), 6);
    for (int k = 0; k < 10; k++) begin
      expectWord(1, k % 4, 1'b0, 1'b0);
      applyTick();
      d = '0;
      d[1*DW +: DW] = DW'((6 + k) % 4);
      applyStimulus(4'b0010, d);
    end
    step(); step();
    checkOutput("wrap occ1 final", occOf(1), 6);

    for (int i = 0; i < 50 && expQ.size() != 0; i++) step();
    checkOutput("scoreboard empty", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
